// File: rtl/mem_rd_arb.sv
// mem_rd_arb: read-request arbiter in front of the DRAM I/O controller.
//
// Several clients share the controller's single read port. Requests are
// issued one at a time. The ID of each granted client goes into an in-order
// tag FIFO, and each returning response is routed to the client at the FIFO
// head.
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   cli_rd_req          per-client read request (held until granted)
//   cli_rd_addr         packed client addresses, client i at [ADDR_W*i +: ADDR_W]
//   cli_rd_gnt          one-hot, one-cycle grant pulse back to the client
//   cli_rd_valid        one-hot, one-cycle response pulse to the issuing client
//   cli_rd_data         response data broadcast to all clients (held between responses)
//   mem_rd_req/addr     request to the controller, held until mem_rd_gnt
//   mem_rd_gnt          controller accept pulse
//   mem_rd_valid/data   controller response
//   rsp_err             sticky flag: a response arrived with no outstanding tag
//
// Build option:
//   MEM_RD_ARB_FIXED_PRIO_EN  when defined, the lowest client index always wins
//                             and there is no round-robin pointer. When undefined
//                             (the default), arbitration is round-robin.
module mem_rd_arb #(
  parameter int NUM_CLIENTS     = 4,
  parameter int ADDR_W          = 28,
  parameter int DATA_W          = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        cli_rd_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_rd_addr,
  output logic [NUM_CLIENTS-1:0]        cli_rd_gnt,
  output logic [NUM_CLIENTS-1:0]        cli_rd_valid,
  output logic [DATA_W-1:0]             cli_rd_data,
  output logic                          mem_rd_req,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  input  logic                          mem_rd_gnt,
  input  logic                          mem_rd_valid,
  input  logic [DATA_W-1:0]             mem_rd_data,
  output logic                          rsp_err
);

  localparam int ID_W  = $clog2(NUM_CLIENTS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic                    mem_rd_req_q, mem_rd_req_d;
  logic [ADDR_W-1:0]       mem_rd_addr_q, mem_rd_addr_d;
  logic [NUM_CLIENTS-1:0]  cli_rd_gnt_q, cli_rd_gnt_d;
  logic [NUM_CLIENTS-1:0]  cli_rd_valid_q, cli_rd_valid_d;
  logic [DATA_W-1:0]       cli_rd_data_q, cli_rd_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ID_W-1:0]         tag_mem_q [MAX_OUTSTANDING];
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
`endif

  logic [ADDR_W-1:0]       addr_arr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]  req_m;
  logic [ID_W:0]           pick_res;
  logic                    push, pop, fifo_full;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_addr
    assign addr_arr[i] = cli_rd_addr[ADDR_W*i +: ADDR_W];
  end

  // Returns {found, id}: the first requesting client at or after start, with wrap.
  // The search runs downward so the closest match to start is the last one assigned.
  function automatic logic [ID_W:0] pick(input logic [NUM_CLIENTS-1:0] req,
                                         input logic [ID_W-1:0]        start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      idx = ID_W'((int'(start) + k) % NUM_CLIENTS);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    mem_rd_req_d  = mem_rd_req_q;
    mem_rd_addr_d = mem_rd_addr_q;
    cli_rd_gnt_d  = '0;
    push          = 1'b0;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif

    // A client whose grant is showing this cycle is still holding its request;
    // masking it keeps the same request from being issued a second time.
    req_m     = cli_rd_req & ~cli_rd_gnt_q;
    fifo_full = (count_q == CNT_W'(MAX_OUTSTANDING));
`ifdef MEM_RD_ARB_FIXED_PRIO_EN
    pick_res  = pick(req_m, '0);
`else
    pick_res  = pick(req_m, rr_ptr_q);
`endif

    case (state_q)
      IDLE: begin
        if (pick_res[ID_W] && !fifo_full) begin
          id_d          = pick_res[ID_W-1:0];
          mem_rd_addr_d = addr_arr[pick_res[ID_W-1:0]];
          mem_rd_req_d  = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rd_gnt) begin
          mem_rd_req_d = 1'b0;
          cli_rd_gnt_d = NUM_CLIENTS'(1) << id_q;
          push         = 1'b1;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
          rr_ptr_d     = (id_q == ID_W'(NUM_CLIENTS - 1)) ? '0 : id_q + ID_W'(1);
`endif
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response routing: the FIFO head is the oldest outstanding request.
    pop            = mem_rd_valid && (count_q != '0);
    cli_rd_valid_d = pop ? (NUM_CLIENTS'(1) << tag_mem_q[rd_ptr_q]) : '0;
    cli_rd_data_d  = pop ? mem_rd_data : cli_rd_data_q;
    rsp_err_d      = rsp_err_q | (mem_rd_valid && (count_q == '0));

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      id_q           <= '0;
      mem_rd_req_q   <= 1'b0;
      mem_rd_addr_q  <= '0;
      cli_rd_gnt_q   <= '0;
      cli_rd_valid_q <= '0;
      cli_rd_data_q  <= '0;
      rsp_err_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      mem_rd_req_q   <= mem_rd_req_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      cli_rd_gnt_q   <= cli_rd_gnt_d;
      cli_rd_valid_q <= cli_rd_valid_d;
      cli_rd_data_q  <= cli_rd_data_d;
      rsp_err_q      <= rsp_err_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
    end
  end

  // Tag storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) tag_mem_q[wr_ptr_q] <= id_q;
  end

  assign cli_rd_gnt   = cli_rd_gnt_q;
  assign cli_rd_valid = cli_rd_valid_q;
  assign cli_rd_data  = cli_rd_data_q;
  assign mem_rd_req   = mem_rd_req_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_mem_rd_arb.sv
// Testbench for mem_rd_arb (default round-robin build, 4 clients).
// A tag model records the client of every grant the bench issues. Each
// response the bench drives pushes an expected {one-hot client, data} entry
// into a scoreboard queue. A monitor pops that queue whenever cli_rd_valid
// pulses.
module tb_mem_rd_arb;

  localparam int NC = 4;
  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct packed {
    logic [NC-1:0] vld;
    logic [DW-1:0] data;
  } rsp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NC-1:0]    cli_rd_req = '0;
  logic [NC*AW-1:0] cli_rd_addr = '0;
  logic [NC-1:0]    cli_rd_gnt;
  logic [NC-1:0]    cli_rd_valid;
  logic [DW-1:0]    cli_rd_data;
  logic             mem_rd_req;
  logic [AW-1:0]    mem_rd_addr;
  logic             mem_rd_gnt = 1'b0;
  logic             mem_rd_valid = 1'b0;
  logic [DW-1:0]    mem_rd_data = '0;
  logic             rsp_err;

  int   checks = 0;
  int   errors = 0;
  int   tag_q[$];
  rsp_t rsp_q[$];
  rsp_t mon_exp;

  mem_rd_arb dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cli_rd_req   (cli_rd_req),
    .cli_rd_addr  (cli_rd_addr),
    .cli_rd_gnt   (cli_rd_gnt),
    .cli_rd_valid (cli_rd_valid),
    .cli_rd_data  (cli_rd_data),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .rsp_err      (rsp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: compares every response pulse with the oldest expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && cli_rd_valid !== '0) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected cli_rd_valid=%b required none", cli_rd_valid);
      end else begin
        mon_exp = rsp_q.pop_front();
        if (cli_rd_valid !== mon_exp.vld || cli_rd_data !== mon_exp.data) begin
          errors++;
          $display("FAIL rsp_route got vld=%b data=%h required vld=%b data=%h",
                   cli_rd_valid, cli_rd_data, mon_exp.vld, mon_exp.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input int id, input logic [AW-1:0] a);
    cli_rd_addr[id*AW +: AW] = a;
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    cli_rd_req   = '0;
    cli_rd_addr  = '0;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    tag_q.delete();
    rsp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Drives one controller response and records where it must be routed.
  task automatic respond(input logic [DW-1:0] d);
    rsp_t e;
    mem_rd_valid = 1'b1;
    mem_rd_data  = d;
    if (tag_q.size() > 0) begin
      e.vld  = NC'(1) << tag_q.pop_front();
      e.data = d;
      rsp_q.push_back(e);
    end
    step();
    mem_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    checks++;
    if (mem_rd_req !== 1'b0 || mem_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_mem got req=%b addr=%h required 0/0", mem_rd_req, mem_rd_addr);
    end
    checks++;
    if (cli_rd_gnt !== '0 || cli_rd_valid !== '0 || cli_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_cli got gnt=%b vld=%b data=%h required zeros", cli_rd_gnt, cli_rd_valid, cli_rd_data);
    end
    checks++;
    if (rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b required 0", rsp_err);
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] d = 128'h11223344556677889900AABBCCDDEEFF;
    int bad = 0;
    apply_reset();
    set_addr(2, 28'h0ABCDEF);
    cli_rd_req = 4'b0100;
    step();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h0ABCDEF) begin
      errors++;
      $display("FAIL single_issue got req=%b addr=%h required 1/0abcdef", mem_rd_req, mem_rd_addr);
    end
    step();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h0ABCDEF || cli_rd_gnt !== '0) begin
      errors++;
      $display("FAIL single_hold got req=%b addr=%h gnt=%b required 1/0abcdef/0000", mem_rd_req, mem_rd_addr, cli_rd_gnt);
    end
    mem_rd_gnt = 1'b1;
    tag_q.push_back(2);
    step();
    mem_rd_gnt = 1'b0;
    checks++;
    if (cli_rd_gnt !== 4'b0100 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt got gnt=%b req=%b required 0100/0", cli_rd_gnt, mem_rd_req);
    end
    cli_rd_req = '0;
    repeat (4) begin
      step();
      if (cli_rd_gnt !== '0 || mem_rd_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_one_gnt got %0d extra grant/request cycles required 0", bad);
    end
    respond(d);
    checks++;
    if (cli_rd_valid !== 4'b0100 || cli_rd_data !== d) begin
      errors++;
      $display("FAIL single_rsp got vld=%b data=%h required 0100/%h", cli_rd_valid, cli_rd_data, d);
    end
    step();
    checks++;
    if (cli_rd_valid !== '0 || cli_rd_data !== d || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL single_rsp_end got vld=%b data=%h pending=%0d required 0000/held/0", cli_rd_valid, cli_rd_data, rsp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int exp;
    apply_reset();
    for (int i = 0; i < NC; i++) set_addr(i, 28'h1000000 + AW'(i));
    cli_rd_req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp = k % NC;
      if (k == 4) begin
        // Four tags outstanding: nothing may issue until a response frees a slot.
        checks++;
        if (mem_rd_req !== 1'b0) begin
          errors++;
          $display("FAIL rr_full got req=%b required 0", mem_rd_req);
        end
        respond(128'hA0);
        step();
      end
      checks++;
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h1000000 + AW'(exp)) begin
        errors++;
        $display("FAIL rr_issue%0d got req=%b addr=%h required 1/%h", k, mem_rd_req, mem_rd_addr, 28'h1000000 + AW'(exp));
      end
      mem_rd_gnt = 1'b1;
      tag_q.push_back(exp);
      step();
      mem_rd_gnt = 1'b0;
      checks++;
      if (cli_rd_gnt !== NC'(1) << exp) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b required %b", k, cli_rd_gnt, NC'(1) << exp);
      end
      step();
    end
    cli_rd_req = '0;
    for (int k = 0; k < 4; k++) respond(128'hB0 + DW'(k));
    step();
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain got %0d pending responses required 0", rsp_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int ids[4] = '{0, 2, 3, 0};
    int bad = 0;
    int n = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set_addr(ids[k], 28'h2000000 + AW'(k));
      cli_rd_req = NC'(1) << ids[k];
      step();
      checks++;
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h2000000 + AW'(k)) begin
        errors++;
        $display("FAIL full_fill%0d got req=%b addr=%h required 1/%h", k, mem_rd_req, mem_rd_addr, 28'h2000000 + AW'(k));
      end
      mem_rd_gnt = 1'b1;
      tag_q.push_back(ids[k]);
      step();
      mem_rd_gnt = 1'b0;
      cli_rd_req = '0;
    end
    set_addr(1, 28'h0555555);
    cli_rd_req = 4'b0010;
    repeat (6) begin
      step();
      if (mem_rd_req !== 1'b0 || cli_rd_gnt !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_block got %0d active cycles required 0", bad);
    end
    respond(128'hC0);
    while (mem_rd_req !== 1'b1 && n < 2) begin
      step();
      n++;
    end
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h0555555) begin
      errors++;
      $display("FAIL full_resume got req=%b addr=%h after %0d cycles required 1/0555555", mem_rd_req, mem_rd_addr, n);
    end
    mem_rd_gnt = 1'b1;
    tag_q.push_back(1);
    step();
    mem_rd_gnt = 1'b0;
    cli_rd_req = '0;
    checks++;
    if (cli_rd_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL full_gnt got %b required 0010", cli_rd_gnt);
    end
    for (int k = 0; k < 4; k++) respond(128'hC1 + DW'(k));
    step();
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain got %0d pending responses required 0", rsp_q.size());
    end
  endtask

  task automatic test_back_to_back_push_pop();
    rsp_t e;
    apply_reset();
    set_addr(1, 28'h0111111);
    set_addr(3, 28'h0333333);
    cli_rd_req = 4'b0010;
    step();
    mem_rd_gnt = 1'b1;
    tag_q.push_back(1);
    step();
    mem_rd_gnt = 1'b0;
    cli_rd_req = 4'b1000;
    step();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h0333333) begin
      errors++;
      $display("FAIL pp_issue got req=%b addr=%h required 1/0333333", mem_rd_req, mem_rd_addr);
    end
    // Grant and response in the same cycle: the response belongs to client 1.
    mem_rd_gnt   = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 128'hD1;
    e.vld  = NC'(1) << tag_q.pop_front();
    e.data = 128'hD1;
    rsp_q.push_back(e);
    tag_q.push_back(3);
    step();
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    cli_rd_req   = '0;
    checks++;
    if (cli_rd_gnt !== 4'b1000 || cli_rd_valid !== 4'b0010 || cli_rd_data !== 128'hD1) begin
      errors++;
      $display("FAIL pp_both got gnt=%b vld=%b data=%h required 1000/0010/d1", cli_rd_gnt, cli_rd_valid, cli_rd_data);
    end
    respond(128'hD3);
    checks++;
    if (cli_rd_valid !== 4'b1000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL pp_second got vld=%b err=%b required 1000/0", cli_rd_valid, rsp_err);
    end
    step();
  endtask

  task automatic test_spurious();
    int bad = 0;
    // FIFO is empty here, so this response has no owner.
    respond(128'hEE);
    checks++;
    if (cli_rd_valid !== '0 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL spur_rsp got vld=%b err=%b required 0000/1", cli_rd_valid, rsp_err);
    end
    repeat (5) begin
      step();
      if (rsp_err !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spur_sticky got %0d cycles with err low required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    set_addr(0, 28'h0AAAAAA);
    set_addr(1, 28'h0BBBBBB);
    set_addr(2, 28'h0CCCCCC);
    for (int k = 0; k < 2; k++) begin
      cli_rd_req = NC'(1) << k;
      step();
      mem_rd_gnt = 1'b1;
      tag_q.push_back(k);
      step();
      mem_rd_gnt = 1'b0;
      cli_rd_req = '0;
    end
    cli_rd_req = 4'b0100;
    step();
    checks++;
    if (mem_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue got req=%b required 1", mem_rd_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_rd_req !== 1'b0 || mem_rd_addr !== '0 || cli_rd_gnt !== '0 ||
        cli_rd_valid !== '0 || cli_rd_data !== '0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got req=%b addr=%h gnt=%b vld=%b err=%b required all 0",
               mem_rd_req, mem_rd_addr, cli_rd_gnt, cli_rd_valid, rsp_err);
    end
    tag_q.delete();
    rsp_q.delete();
    cli_rd_req = '0;
    step();
    reset_n = 1'b1;
    step();
    // Tags issued before reset are gone, so this response is spurious.
    respond(128'hF0);
    checks++;
    if (cli_rd_valid !== '0 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_lost got vld=%b err=%b required 0000/1", cli_rd_valid, rsp_err);
    end
    cli_rd_req = 4'b0100;
    step();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 28'h0CCCCCC) begin
      errors++;
      $display("FAIL mid_resume got req=%b addr=%h required 1/0cccccc", mem_rd_req, mem_rd_addr);
    end
    mem_rd_gnt = 1'b1;
    tag_q.push_back(2);
    step();
    mem_rd_gnt = 1'b0;
    cli_rd_req = '0;
    checks++;
    if (cli_rd_gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mid_gnt got %b required 0100", cli_rd_gnt);
    end
    respond(128'hF2);
    step();
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drain got %0d pending responses required 0", rsp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_back_to_back_push_pop();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
